icache_line_loader: RTL and testbench
=====================================

// Module: icache_line_loader
// PURPOSE
// - Parametrised successor to the byte-serial i-cache programming path: collects DATA_W-bit beats
//   into one LINE_W cacheline plus a target line index, then writes it to the i-cache fill port.
// - Sits between the external programming device (beats pre-synchronised to clock_i) and the
//   i-cache write side of PA_Core; replaces the shift-strobe scheme with valid/ready handshakes.
// PARAMETERS
// - DATA_W  8    beat width in bits; LINE_W % DATA_W == 0 and ADDR_W <= DATA_W are required
// - LINE_W  256  cacheline width in bits; BEATS = LINE_W/DATA_W
// - ADDR_W  8    cacheline index width, taken from beatData_i[ADDR_W-1:0] of an address beat
// PORTS
// - clock_i        in   1                      single clock, rising edge
// - reset_i        in   1                      synchronous, active-low
// - beatValid_i    in   1                      beat offered
// - beatReady_o    out  1                      beat accepted when beatValid_i && beatReady_o
// - beatData_i     in   DATA_W                 beat payload
// - isAddress_i    in   1                      1: beat is the line index; 0: beat is line data
// - commit_i       in   1                      single-cycle pulse requesting the line be written
// - lineValid_o    out  1                      fill request to i-cache
// - lineReady_i    in   1                      i-cache accepts the fill
// - lineAddr_o     out  ADDR_W                 cacheline index
// - lineData_o     out  LINE_W                 cacheline; beat k at [k*DATA_W +: DATA_W]
// - beatCount_o    out  $clog2(BEATS)+1        data beats held for the current line
// - error_o        out  1                      one-cycle protocol-error pulse
// BEHAVIOUR
// - Reset (reset_i==0 at an edge): state=IDLE; lineValid_o, lineAddr_o, lineData_o,
//   beatCount_o, error_o = 0. Reset mid-operation discards any partial or pending line.
// - beatReady_o is combinational from state: 1 in IDLE/LOAD (and CHECK), 0 in FULL/PUSH.
// - IDLE: address beat -> latch lineAddr_o, clear lineData_o, beatCount_o=0, go LOAD.
//   Data beat in IDLE -> dropped, error_o pulses. commit_i in IDLE -> ignored, no error.
// - LOAD: data beat -> written to slot beatCount_o, count+1; at count==BEATS go FULL.
//   An address beat restarts the line: new addr, count=0, lineData_o cleared, no error.
//   commit_i with count<BEATS (and no completing beat that cycle) -> error_o pulse, discard, IDLE.
// - FULL: commit_i -> PUSH; lineValid_o=1 on the next cycle (1-cycle commit latency).
//   A final beat and commit_i in the same cycle -> straight to PUSH.
// - PUSH: lineValid_o held 1; lineAddr_o and lineData_o stay stable until lineReady_i.
//   Handshake at edge N -> IDLE, lineValid_o=0 and beatCount_o=0 from N+1. No beats accepted.
// - error_o is registered: it is high exactly one cycle after the offending edge.
// - Beat ordering matches the legacy loader: the first data beat fills the least-significant bits.
// CONFIGURATION
// - LOADER_CHECKSUM_EN defined: after BEATS data beats the FSM enters CHECK (beatReady_o=1)
//   and expects one extra data beat = XOR of all data beats. Match -> FULL. Mismatch -> error_o
//   pulse, discard, IDLE. commit_i before the checksum beat -> error, discard, IDLE. An address
//   beat in CHECK restarts the line as in LOAD.
// - LOADER_CHECKSUM_EN undefined: no CHECK state; LOAD goes directly to FULL; no extra beat.
// TESTING (DATA_W=8, LINE_W=256, ADDR_W=8)
// - Addr beat 0x03, data 0x00..0x1F, commit, lineReady_i=1 -> lineValid_o 1 cycle after commit,
//   lineAddr_o=0x03, lineData_o[7:0]=0x00, [255:248]=0x1F; IDLE next cycle.
// - Same load, lineReady_i=0 for 5 cycles -> lineValid_o/addr/data stable, beatReady_o=0;
//   ready high -> single handshake, then lineValid_o=0.
// - Addr 0x05, 10 data beats, commit -> error_o high 1 cycle, no lineValid_o, beatCount_o=0.
// - Addr 0x05, 5 beats, addr 0x07, 32 beats, commit -> lineAddr_o=0x07, beatCount_o=32.
// - reset_i=0 after 12 data beats -> next cycle all outputs at reset values;
//   a following full load completes normally.
// - Data beat with no prior address beat -> dropped, error_o pulse, beatCount_o stays 0.
// - LOADER_CHECKSUM_EN: data 0x01..0x20 + checksum 0x20 -> line pushed;
//   checksum 0x21 -> error_o pulse, no lineValid_o.

Source files
------------

// File: rtl/icache_line_loader.sv
// icache_line_loader: gathers DATA_W-bit beats into one LINE_W cacheline plus a
// line index, then offers the line to the i-cache fill port.
// Optional feature macro: LOADER_CHECKSUM_EN. When defined, an extra XOR checksum
// beat must follow the data beats before the line can be committed.
//
// Handshakes: a beat transfers on a rising edge where beatValid_i && beatReady_o;
// a line transfers on a rising edge where lineValid_o && lineReady_i. lineValid_o,
// lineAddr_o and lineData_o hold steady while lineValid_o is high and the i-cache
// has not yet accepted the line.
module icache_line_loader #(
  parameter int DATA_W = 8,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 8
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               beatValid_i,
  output logic                               beatReady_o,
  input  logic [DATA_W-1:0]                  beatData_i,
  input  logic                               isAddress_i,
  input  logic                               commit_i,
  output logic                               lineValid_o,
  input  logic                               lineReady_i,
  output logic [ADDR_W-1:0]                  lineAddr_o,
  output logic [LINE_W-1:0]                  lineData_o,
  output logic [$clog2(LINE_W/DATA_W):0]     beatCount_o,
  output logic                               error_o
);

  localparam int BEATS = LINE_W / DATA_W;
  localparam int CNT_W = $clog2(BEATS) + 1;
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(BEATS - 1);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_FULL  = 3'd3,
    S_PUSH  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FULL  = 3'd3,
    S_PUSH  = 3'd4
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                err_q, err_d;
  logic                beat_acc;
  int                  slot;

  // Beats are accepted in every state except while a full line is waiting.
  always_comb begin
    beatReady_o = 1'b0;
    case (state_q)
      S_IDLE, S_LOAD: beatReady_o = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK:        beatReady_o = 1'b1;
`endif
      default:        beatReady_o = 1'b0;
    endcase
  end

  assign beat_acc = beatValid_i && beatReady_o;
  assign slot     = int'(count_q);

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  // Running XOR of the data beats of the current line; cleared by an address beat.
  always_comb begin
    csum_d = csum_q;
    if (beat_acc) begin
      if (isAddress_i)             csum_d = '0;
      else if (state_q == S_LOAD)  csum_d = csum_q ^ beatData_i;
    end
  end
`endif

  // Next-state and datapath updates; an address beat in any accepting state starts a fresh line.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = count_q;
    err_d   = 1'b0;
    if (beat_acc && isAddress_i) begin
      state_d = S_LOAD;
      addr_d  = beatData_i[ADDR_W-1:0];
      data_d  = '0;
      count_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Data without a preceding address has nowhere to go.
          if (beat_acc) err_d = 1'b1;
        end
        S_LOAD: begin
          if (beat_acc) begin
            data_d[slot*DATA_W +: DATA_W] = beatData_i;
            count_d = count_q + CNT_W'(1);
            if (count_q == LAST_C) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = S_CHECK;
              if (commit_i) begin
                // Commit arrived before the checksum beat.
                err_d   = 1'b1;
                state_d = S_IDLE;
                count_d = '0;
              end
`else
              state_d = commit_i ? S_PUSH : S_FULL;
`endif
            end else if (commit_i) begin
              err_d   = 1'b1;
              state_d = S_IDLE;
              count_d = '0;
            end
          end else if (commit_i) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
            count_d = '0;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (beat_acc) begin
            if (beatData_i == csum_q) begin
              state_d = commit_i ? S_PUSH : S_FULL;
            end else begin
              err_d   = 1'b1;
              state_d = S_IDLE;
              count_d = '0;
            end
          end else if (commit_i) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
            count_d = '0;
          end
        end
`endif
        S_FULL: begin
          if (commit_i) state_d = S_PUSH;
        end
        S_PUSH: begin
          if (lineReady_i) begin
            state_d = S_IDLE;
            count_d = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      count_q <= count_d;
      err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign lineValid_o = (state_q == S_PUSH);
  assign lineAddr_o  = addr_q;
  assign lineData_o  = data_q;
  assign beatCount_o = count_q;
  assign error_o     = err_q;

endmodule

// File: tb/tb_icache_line_loader.sv
// Directed testbench for icache_line_loader (DATA_W=8, LINE_W=256, ADDR_W=8).
// Build with +define+LOADER_CHECKSUM_EN to exercise the checksum beat.
module tb_icache_line_loader;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         beat_valid;
  logic         beat_ready;
  logic [7:0]   beat_data;
  logic         is_addr;
  logic         commit;
  logic         line_valid;
  logic         line_ready;
  logic [7:0]   line_addr;
  logic [255:0] line_data;
  logic [5:0]   beat_count;
  logic         err;

  int total = 0;
  int bad   = 0;
  logic [255:0] exp_q[$];
  logic [255:0] exp_line;

  // Clock and reset
  always #5 clk = ~clk;

  icache_line_loader dut (
    .clock_i     (clk),
    .reset_i     (reset_n),
    .beatValid_i (beat_valid),
    .beatReady_o (beat_ready),
    .beatData_i  (beat_data),
    .isAddress_i (is_addr),
    .commit_i    (commit),
    .lineValid_o (line_valid),
    .lineReady_i (line_ready),
    .lineAddr_o  (line_addr),
    .lineData_o  (line_data),
    .beatCount_o (beat_count),
    .error_o     (err)
  );

  // Driver tasks: inputs change 1ns after the rising edge, outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_beat(input logic a, input logic [7:0] d, input logic c);
    beat_valid = 1'b1;
    is_addr    = a;
    beat_data  = d;
    commit     = c;
    tick();
    beat_valid = 1'b0;
    is_addr    = 1'b0;
    commit     = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  // Address beat, n data beats base+i, and the checksum beat when a full line is sent.
  task automatic load_line(input logic [7:0] addr, input logic [7:0] base, input int n,
                           output logic [255:0] line);
    logic [7:0] d;
    logic [7:0] x;
    line = '0;
    x    = '0;
    put_beat(1'b1, addr, 1'b0);
    for (int i = 0; i < n; i++) begin
      d = base + 8'(i);
      line[i*8 +: 8] = d;
      x = x ^ d;
      put_beat(1'b0, d, 1'b0);
    end
`ifdef LOADER_CHECKSUM_EN
    if (n == 32) put_beat(1'b0, x, 1'b0);
`endif
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", line_valid); end
    total++; if (line_addr !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h exp=00", line_addr); end
    total++; if (line_data !== 256'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", line_data); end
    total++; if (beat_count !== 6'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", beat_count); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    total++; if (beat_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", beat_ready); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_push();
    logic [255:0] ln;
    line_ready = 1'b1;
    load_line(8'h03, 8'h00, 32, ln);
    exp_q.push_back(ln);
    total++; if (beat_count !== 6'd32) begin bad++; $display("FAIL basic_count got=%0d exp=32", beat_count); end
    total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL basic_prevalid got=%b exp=0", line_valid); end
    total++; if (beat_ready !== 1'b0) begin bad++; $display("FAIL basic_full_ready got=%b exp=0", beat_ready); end
    pulse_commit();
    exp_line = exp_q.pop_front();
    total++; if (line_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", line_valid); end
    total++; if (line_addr !== 8'h03) begin bad++; $display("FAIL basic_addr got=%h exp=03", line_addr); end
    total++; if (line_data[7:0] !== 8'h00) begin bad++; $display("FAIL basic_lsb got=%h exp=00", line_data[7:0]); end
    total++; if (line_data[255:248] !== 8'h1F) begin bad++; $display("FAIL basic_msb got=%h exp=1f", line_data[255:248]); end
    total++; if (line_data !== exp_line) begin bad++; $display("FAIL basic_data got=%h exp=%h", line_data, exp_line); end
    tick();
    total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL basic_post_valid got=%b exp=0", line_valid); end
    total++; if (beat_count !== 6'd0) begin bad++; $display("FAIL basic_post_count got=%0d exp=0", beat_count); end
    total++; if (beat_ready !== 1'b1) begin bad++; $display("FAIL basic_post_ready got=%b exp=1", beat_ready); end
  endtask

  task automatic test_stall();
    logic [255:0] ln;
    line_ready = 1'b0;
    load_line(8'h03, 8'h40, 32, ln);
    exp_q.push_back(ln);
    pulse_commit();
    exp_line = exp_q.pop_front();
    // Offer an address beat throughout the stall; it must not be taken.
    beat_valid = 1'b1;
    is_addr    = 1'b1;
    beat_data  = 8'hEE;
    for (int c = 0; c < 5; c++) begin
      total++; if (line_valid !== 1'b1) begin bad++; $display("FAIL stall_valid c%0d got=%b exp=1", c, line_valid); end
      total++; if (line_addr !== 8'h03) begin bad++; $display("FAIL stall_addr c%0d got=%h exp=03", c, line_addr); end
      total++; if (line_data !== exp_line) begin bad++; $display("FAIL stall_data c%0d got=%h exp=%h", c, line_data, exp_line); end
      total++; if (beat_ready !== 1'b0) begin bad++; $display("FAIL stall_ready c%0d got=%b exp=0", c, beat_ready); end
      total++; if (beat_count !== 6'd32) begin bad++; $display("FAIL stall_count c%0d got=%0d exp=32", c, beat_count); end
      tick();
    end
    beat_valid = 1'b0;
    is_addr    = 1'b0;
    line_ready = 1'b1;
    tick();
    total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL stall_release got=%b exp=0", line_valid); end
    total++; if (beat_count !== 6'd0) begin bad++; $display("FAIL stall_rel_count got=%0d exp=0", beat_count); end
    tick();
    total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL stall_single got=%b exp=0", line_valid); end
  endtask

  task automatic test_short_commit();
    logic [255:0] ln;
    load_line(8'h05, 8'h10, 10, ln);
    total++; if (beat_count !== 6'd10) begin bad++; $display("FAIL short_count got=%0d exp=10", beat_count); end
    pulse_commit();
    total++; if (err !== 1'b1) begin bad++; $display("FAIL short_err got=%b exp=1", err); end
    total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL short_valid got=%b exp=0", line_valid); end
    total++; if (beat_count !== 6'd0) begin bad++; $display("FAIL short_cnt0 got=%0d exp=0", beat_count); end
    tick();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL short_err_len got=%b exp=0", err); end
    total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL short_valid2 got=%b exp=0", line_valid); end
  endtask

  task automatic test_restart();
    logic [255:0] ln;
    load_line(8'h05, 8'h80, 5, ln);
    load_line(8'h07, 8'h20, 32, ln);
    exp_q.push_back(ln);
    total++; if (beat_count !== 6'd32) begin bad++; $display("FAIL restart_count got=%0d exp=32", beat_count); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL restart_err got=%b exp=0", err); end
    pulse_commit();
    exp_line = exp_q.pop_front();
    total++; if (line_valid !== 1'b1) begin bad++; $display("FAIL restart_valid got=%b exp=1", line_valid); end
    total++; if (line_addr !== 8'h07) begin bad++; $display("FAIL restart_addr got=%h exp=07", line_addr); end
    total++; if (line_data !== exp_line) begin bad++; $display("FAIL restart_data got=%h exp=%h", line_data, exp_line); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [255:0] ln;
    load_line(8'h09, 8'h30, 12, ln);
    reset_n = 1'b0;
    tick();
    total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", line_valid); end
    total++; if (line_addr !== 8'h00) begin bad++; $display("FAIL rmid_addr got=%h exp=00", line_addr); end
    total++; if (line_data !== 256'h0) begin bad++; $display("FAIL rmid_data got=%h exp=0", line_data); end
    total++; if (beat_count !== 6'd0) begin bad++; $display("FAIL rmid_count got=%0d exp=0", beat_count); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rmid_err got=%b exp=0", err); end
    reset_n = 1'b1;
    load_line(8'h0A, 8'hA0, 32, ln);
    exp_q.push_back(ln);
    pulse_commit();
    exp_line = exp_q.pop_front();
    total++; if (line_valid !== 1'b1) begin bad++; $display("FAIL rmid_push_valid got=%b exp=1", line_valid); end
    total++; if (line_addr !== 8'h0A) begin bad++; $display("FAIL rmid_push_addr got=%h exp=0a", line_addr); end
    total++; if (line_data !== exp_line) begin bad++; $display("FAIL rmid_push_data got=%h exp=%h", line_data, exp_line); end
    tick();
  endtask

  task automatic test_orphan_data();
    put_beat(1'b0, 8'h55, 1'b0);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL orphan_err got=%b exp=1", err); end
    total++; if (beat_count !== 6'd0) begin bad++; $display("FAIL orphan_count got=%0d exp=0", beat_count); end
    tick();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL orphan_err_len got=%b exp=0", err); end
    pulse_commit();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL idle_commit_err got=%b exp=0", err); end
    total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL idle_commit_valid got=%b exp=0", line_valid); end
  endtask

  // Commit rides on the last beat of the line, so the fill request follows immediately.
  task automatic test_back_to_back();
    logic [255:0] ln;
    logic [7:0] d;
    logic [7:0] x;
    ln = '0;
    x  = '0;
    put_beat(1'b1, 8'h0C, 1'b0);
    for (int i = 0; i < 32; i++) begin
      d = 8'h60 + 8'(i);
      ln[i*8 +: 8] = d;
      x = x ^ d;
`ifdef LOADER_CHECKSUM_EN
      put_beat(1'b0, d, 1'b0);
`else
      put_beat(1'b0, d, i == 31);
`endif
    end
`ifdef LOADER_CHECKSUM_EN
    put_beat(1'b0, x, 1'b1);
`endif
    exp_q.push_back(ln);
    exp_line = exp_q.pop_front();
    total++; if (line_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b exp=1", line_valid); end
    total++; if (line_addr !== 8'h0C) begin bad++; $display("FAIL b2b_addr got=%h exp=0c", line_addr); end
    total++; if (line_data !== exp_line) begin bad++; $display("FAIL b2b_data got=%h exp=%h", line_data, exp_line); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL b2b_err got=%b exp=0", err); end
    tick();
    total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL b2b_done got=%b exp=0", line_valid); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [255:0] ln;
    load_line(8'h11, 8'h01, 32, ln);
    exp_q.push_back(ln);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL csum_good_err got=%b exp=0", err); end
    pulse_commit();
    exp_line = exp_q.pop_front();
    total++; if (line_valid !== 1'b1) begin bad++; $display("FAIL csum_good_valid got=%b exp=1", line_valid); end
    total++; if (line_data !== exp_line) begin bad++; $display("FAIL csum_good_data got=%h exp=%h", line_data, exp_line); end
    tick();
    put_beat(1'b1, 8'h12, 1'b0);
    for (int i = 0; i < 32; i++) put_beat(1'b0, 8'h01 + 8'(i), 1'b0);
    total++; if (beat_ready !== 1'b1) begin bad++; $display("FAIL csum_check_ready got=%b exp=1", beat_ready); end
    put_beat(1'b0, 8'h21, 1'b0);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL csum_bad_err got=%b exp=1", err); end
    total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL csum_bad_valid got=%b exp=0", line_valid); end
    total++; if (beat_count !== 6'd0) begin bad++; $display("FAIL csum_bad_count got=%0d exp=0", beat_count); end
    pulse_commit();
    total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL csum_bad_nopush got=%b exp=0", line_valid); end
  endtask
`endif

  initial begin
    reset_n    = 1'b0;
    beat_valid = 1'b0;
    beat_data  = 8'h00;
    is_addr    = 1'b0;
    commit     = 1'b0;
    line_ready = 1'b0;
    test_reset();
    test_basic_push();
    test_stall();
    test_short_commit();
    test_restart();
    test_reset_mid();
    test_orphan_data();
    test_back_to_back();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
